fpu_arbiter: RTL and testbench

Shares one `fpu` instance between `NREQ` requesters (integer pipeline, load/store helper, debug port) with round-robin arbitration. It accepts one request at a time, drives the FPU start/opcode/operand inputs, and waits for the FPU result pulse. It returns the result to the granted requester, and rejects illegal opcodes and hung operations instead of letting the FPU stall forever. It sits between the core's execute stage and `fpu`, replacing the direct `AorF` wiring.

---
 rtl/fpu_arbiter.sv | 135 +++++++++++++
 tb/tb_fpu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NREQ requesters.
// Filters illegal opcodes and aborts operations that never complete.
//
// state | meaning
// IDLE  | waiting for any req_valid, grant issued combinationally
// ISSUE | fpu_start pulse, counter cleared
// WAIT  | counting cycles until fpu_valid or TIMEOUT
// RESP  | result strobe to the granted requester
// ERR   | error strobe (illegal opcode or timeout)
module fpu_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [4*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_op1,
   input  logic [32*NREQ-1:0]   req_op2,
   output logic [NREQ-1:0]      resp_valid,
   output logic [31:0]          resp_data,
   output logic                 resp_err,
   output logic                 fpu_start,
   output logic [3:0]           fpu_op,
   output logic [31:0]          fpu_a,
   output logic [31:0]          fpu_b,
   input  logic [31:0]          fpu_result,
   input  logic                 fpu_valid,
   output logic                 fpu_abort,
   output logic                 busy
);

   localparam int GW = (NREQ > 2) ? 2 : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

   state_t          state;
   logic [GW-1:0]   last;
   logic [GW-1:0]   gnt;
   logic [GW-1:0]   grant;
   logic            any;
   logic [15:0]     cnt;
   logic [3:0]      op_sel;
   logic [31:0]     a_sel;
   logic [31:0]     b_sel;
   logic            timed_out;

   function automatic logic legal_op(input logic [3:0] op);
      case (op)
         4'b0011, 4'b0100, 4'b1110, 4'b1101,
         4'b1100, 4'b1011, 4'b1010: legal_op = 1'b1;
         default:                   legal_op = 1'b0;
      endcase
   endfunction

   // Search upward from the requester after the last grant, wrapping.
   always_comb begin : grant_search
      int idx;
      idx   = 0;
      any   = 1'b0;
      grant = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = (int'(last) + i) % NREQ;
         if (!any && req_valid[idx]) begin
            any   = 1'b1;
            grant = GW'(idx);
         end
      end
   end

   assign op_sel = req_op[int'(grant)*4 +: 4];
   assign a_sel  = req_op1[int'(grant)*32 +: 32];
   assign b_sel  = req_op2[int'(grant)*32 +: 32];

   assign timed_out  = (cnt == 16'(TIMEOUT));
   assign req_ready  = (state == IDLE && !reset && any) ? (NREQ'(1) << grant) : '0;
   assign fpu_start  = (state == ISSUE);
   assign fpu_abort  = (state == WAIT) && !fpu_valid && timed_out;
   assign resp_valid = (state == RESP || state == ERR) ? (NREQ'(1) << gnt) : '0;
   assign resp_err   = (state == ERR);
   assign busy       = (state != IDLE);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         last      <= GW'(NREQ-1);
         gnt       <= '0;
         cnt       <= '0;
         fpu_op    <= '0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         resp_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  gnt  <= grant;
                  last <= grant;
                  // Illegal opcodes never reach the FPU's operand bus.
                  if (legal_op(op_sel)) begin
                     fpu_op <= op_sel;
                     fpu_a  <= a_sel;
                     fpu_b  <= b_sel;
                     state  <= ISSUE;
                  end else begin
                     resp_data <= '0;
                     state     <= ERR;
                  end
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // A result arriving on the timeout cycle still wins.
               if (fpu_valid) begin
                  resp_data <= fpu_result;
                  state     <= RESP;
               end else if (timed_out) begin
                  resp_data <= 32'hFFFF_FFFF;
                  state     <= ERR;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a timestamp-based reference model
// and a simple latency-programmable FPU stand-in.
module tb_fpu_arbiter;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 8;

   logic              CLK = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_op;
   logic [32*NREQ-1:0] req_op1, req_op2;
   logic [NREQ-1:0]   resp_valid;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic              fpu_start;
   logic [3:0]        fpu_op;
   logic [31:0]       fpu_a, fpu_b;
   logic [31:0]       fpu_result;
   logic              fpu_valid, fpu_valid_m, stray;
   logic              fpu_abort;
   logic              busy;

   assign fpu_valid = fpu_valid_m | stray;

   fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_result(fpu_result), .fpu_valid(fpu_valid), .fpu_abort(fpu_abort),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // FPU stand-in: answers known vectors, anything else gets a scrambled value.
   function automatic logic [31:0] fpu_func(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 4'b0011 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (op == 4'b0100 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
      if (op == 4'b1110 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (op == 4'b1010) return ($signed(a) < 0 && $signed(b) >= 0) ? 32'd1 : 32'd0;
      if (op == 4'b1100) return (a == b) ? 32'd1 : 32'd0;
      return a ^ b ^ {28'h0, op};
   endfunction

   int fpu_lat = 5;
   initial begin
      logic [3:0]  f_op;
      logic [31:0] f_a, f_b;
      logic        killed;
      fpu_valid_m = 1'b0;
      fpu_result  = '0;
      forever begin
         @(negedge CLK);
         if (fpu_start && !reset && fpu_lat > 0) begin
            f_op = fpu_op; f_a = fpu_a; f_b = fpu_b;
            killed = 1'b0;
            repeat (fpu_lat) begin
               @(posedge CLK);
               if (reset) killed = 1'b1;
            end
            if (!killed) begin
               #1;
               fpu_valid_m = 1'b1;
               fpu_result  = fpu_func(f_op, f_a, f_b);
               @(posedge CLK);
               #1;
               fpu_valid_m = 1'b0;
               fpu_result  = 32'hDEAD_BEEF;
            end
         end
      end
   end

   // Observation log of responses, filled from DUT pins.
   int          log_g[$];
   logic        log_err[$];
   logic [31:0] log_data[$];
   int          acc_cyc = 0, resp_cyc = 0, abort_cnt = 0;
   logic [NREQ-1:0] acc_mask = '0;

   // Reference model: each grant schedules when start/response/idle must happen.
   int          m_last = NREQ-1;
   int          m_g = 0, m_free = 0, m_start = -1, m_wlo = -1, m_whi = -1, m_resp = -1;
   logic        m_waiting = 1'b0;
   logic        m_err = 1'b0;
   logic [31:0] m_data = '0;
   logic [3:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0;

   always @(negedge CLK) begin
      logic [NREQ-1:0] exp_ready;
      logic            exp_abort, idle, wt, found;
      int              g;
      acc_mask = req_valid & req_ready;
      if (acc_mask != 0) acc_cyc = cyc;
      if (resp_valid != 0) begin
         log_g.push_back(resp_valid[1] ? 1 : 0);
         log_err.push_back(resp_err);
         log_data.push_back(resp_data);
         resp_cyc = cyc;
      end
      if (fpu_abort) abort_cnt++;
      if (reset) begin
         check("reset_ctl", {req_ready, resp_valid, resp_err, fpu_start, fpu_abort, busy}, 0);
         check("reset_data", resp_data | fpu_a | fpu_b | {28'h0, fpu_op}, 0);
         m_last = NREQ-1; m_free = cyc; m_start = -1; m_resp = -1; m_waiting = 1'b0;
      end else begin
         exp_ready = '0;
         exp_abort = 1'b0;
         idle  = (cyc >= m_free);
         wt    = m_waiting && cyc >= m_wlo;
         found = 1'b0;
         g     = 0;
         if (idle) begin
            for (int i = 1; i <= NREQ; i++) begin
               if (!found && req_valid[(m_last + i) % NREQ]) begin
                  found = 1'b1;
                  g = (m_last + i) % NREQ;
               end
            end
         end
         if (found) begin
            exp_ready = NREQ'(1) << g;
            m_g = g; m_last = g;
            m_op = req_op[4*g +: 4];
            m_a  = req_op1[32*g +: 32];
            m_b  = req_op2[32*g +: 32];
            if (m_op inside {4'b0011, 4'b0100, 4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1010}) begin
               m_start = cyc + 1; m_wlo = cyc + 2; m_whi = cyc + 2 + TIMEOUT;
               m_waiting = 1'b1; m_resp = -1; m_free = 32'h7FFF_FFFF;
            end else begin
               m_resp = cyc + 1; m_err = 1'b1; m_data = '0; m_free = cyc + 2;
            end
         end
         if (wt) begin
            if (fpu_valid) begin
               m_resp = cyc + 1; m_err = 1'b0; m_data = fpu_result;
               m_free = cyc + 2; m_waiting = 1'b0;
            end else if (cyc == m_whi) begin
               exp_abort = 1'b1;
               m_resp = cyc + 1; m_err = 1'b1; m_data = 32'hFFFF_FFFF;
               m_free = cyc + 2; m_waiting = 1'b0;
            end
         end
         check("req_ready", req_ready, exp_ready);
         check("fpu_start", fpu_start, cyc == m_start);
         check("fpu_abort", fpu_abort, exp_abort);
         check("busy", busy, !idle);
         check("resp_valid", resp_valid, (cyc == m_resp) ? (NREQ'(1) << m_g) : '0);
         if (cyc == m_resp) begin
            check("resp_err", resp_err, m_err);
            check("resp_data", resp_data, m_data);
         end
         if (cyc == m_start || wt)
            check("fpu_operands", {fpu_op ^ fpu_a[3:0], fpu_a ^ fpu_b}, {m_op ^ m_a[3:0], m_a ^ m_b});
      end
   end

   logic [NREQ-1:0] hold_mask;

   task automatic tick();
      @(posedge CLK);
      #1;
      req_valid = req_valid & ~(acc_mask & ~hold_mask);
   endtask

   task automatic present(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[4*k +: 4]   = op;
      req_op1[32*k +: 32] = a;
      req_op2[32*k +: 32] = b;
      req_valid[k] = 1'b1;
   endtask

   task automatic wait_resps(input string name, input int n, input int budget);
      int target;
      int k;
      target = log_g.size() + n;
      k = 0;
      while (log_g.size() < target && k < budget) begin
         tick();
         k++;
      end
      check({name, "_done"}, (log_g.size() >= target) ? 1 : 0, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int i0, n, ab;
      reset = 1'b1; stray = 1'b0; req_valid = '0; hold_mask = '0;
      req_op = '0; req_op1 = '0; req_op2 = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("idle_after_reset", {busy, resp_valid}, 0);

      // single fadd, latency 5
      i0 = log_g.size();
      present(0, 4'b0011, 32'h3F800000, 32'h40000000);
      wait_resps("fadd", 1, 40);
      check("fadd_data", log_data[i0], 32'h40400000);
      check("fadd_g", log_g[i0], 0);
      check("fadd_err", log_err[i0], 0);
      check("fadd_latency", resp_cyc - acc_cyc, 7);

      // round robin, both held
      do_reset();
      i0 = log_g.size();
      hold_mask = 2'b11;
      present(0, 4'b1110, 32'h40000000, 32'h40400000);
      present(1, 4'b1110, 32'h40000000, 32'h40400000);
      wait_resps("rr", 4, 100);
      hold_mask = '0;
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         check("rr_g", log_g[i0+i], i % 2);
         check("rr_data", log_data[i0+i], 32'h40C00000);
      end

      // comparisons
      i0 = log_g.size();
      present(1, 4'b1010, 32'hBF800000, 32'h3F800000);
      wait_resps("fclt", 1, 40);
      check("fclt_data", log_data[i0], 32'h00000001);
      present(0, 4'b1100, 32'h41200000, 32'h41200000);
      wait_resps("fceq", 1, 40);
      check("fceq_data", log_data[i0+1], 32'h00000001);

      // illegal opcode
      i0 = log_g.size();
      present(1, 4'b0111, 32'h12345678, 32'h9ABCDEF0);
      wait_resps("illegal", 1, 20);
      check("illegal_g", log_g[i0], 1);
      check("illegal_err", log_err[i0], 1);
      check("illegal_data", log_data[i0], 0);
      check("illegal_latency", resp_cyc - acc_cyc, 1);

      // timeout, then normal service
      i0 = log_g.size();
      ab = abort_cnt;
      fpu_lat = 0;
      present(0, 4'b0011, 32'h3F800000, 32'h40000000);
      wait_resps("timeout", 1, 40);
      check("timeout_err", log_err[i0], 1);
      check("timeout_data", log_data[i0], 32'hFFFFFFFF);
      check("timeout_aborts", abort_cnt - ab, 1);
      check("timeout_latency", resp_cyc - acc_cyc, 11);
      fpu_lat = 5;
      present(1, 4'b0100, 32'h40400000, 32'h3F800000);
      wait_resps("post_timeout", 1, 40);
      check("post_timeout_data", log_data[i0+1], 32'h40000000);
      check("post_timeout_err", log_err[i0+1], 0);

      // reset during WAIT, stray fpu_valid in IDLE
      present(1, 4'b1110, 32'h40000000, 32'h40400000);
      repeat (4) tick();
      check("busy_in_wait", busy, 1);
      n = log_g.size();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      repeat (8) tick();
      check("no_resp_after_reset", log_g.size(), n);
      present(0, 4'b0011, 32'h3F800000, 32'h40000000);
      present(1, 4'b1110, 32'h40000000, 32'h40400000);
      wait_resps("post_reset", 2, 60);
      check("post_reset_first_g", log_g[n], 0);
      check("post_reset_first_data", log_data[n], 32'h40400000);
      check("post_reset_second_g", log_g[n+1], 1);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
endmodule
